// File: rtl/exec_sequencer_if.sv
// Instruction, register-file and status bundle between a decoder / register
// file (master side) and the execution sequencer (slave side).
interface exec_sequencer_if #(
   parameter int DATA_W = 16
) ();

   logic              inst_valid;
   logic              inst_ready;
   logic [2:0]        opcode;
   logic [2:0]        rd;
   logic [2:0]        rs1;
   logic [2:0]        rs2;
   logic [2:0]        regSource1;
   logic [2:0]        regSource2;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic [2:0]        regDestination;
   logic [DATA_W-1:0] writeData;
   logic              writeEnable;
   logic              busy;
   logic              done;
   logic              flag_zero;
   logic              flag_carry;

   // Decoder plus register file: presents instructions and read data.
   modport master (
      output inst_valid, opcode, rd, rs1, rs2, data1, data2,
      input  inst_ready, regSource1, regSource2, regDestination,
             writeData, writeEnable, busy, done, flag_zero, flag_carry
   );

   // Sequencer: accepts instructions and drives the register-file ports.
   modport slave (
      input  inst_valid, opcode, rd, rs1, rs2, data1, data2,
      output inst_ready, regSource1, regSource2, regDestination,
             writeData, writeEnable, busy, done, flag_zero, flag_carry
   );

endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: accepts one instruction at a time, reads
// both operands from the register file, runs a single-cycle ALU operation or
// a 16-step shift-add multiply, then writes the result back for one cycle.
module exec_sequencer #(
   parameter int DATA_W = 16
) (
   input logic           clock,
   input logic           reset,
   exec_sequencer_if.slave bus
);

   localparam int SHIFT_W = $clog2(DATA_W);
   localparam int CNT_W   = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_MUL,
      ST_WB
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } opcode_t;

   state_t                r_state;
   opcode_t               r_opcode;
   logic [2:0]            r_rd;
   logic [2:0]            r_regSource1;
   logic [2:0]            r_regSource2;
   logic [2:0]            r_regDestination;
   logic [DATA_W-1:0]     r_opA;
   logic [DATA_W-1:0]     r_opB;
   logic [DATA_W-1:0]     r_result;
   logic [2*DATA_W-1:0]   r_mulProd;
   logic [CNT_W-1:0]      r_mulCount;
   logic                  r_instReady;
   logic                  r_busy;
   logic                  r_writeEnable;
   logic                  r_done;
   logic                  r_flagZero;
   logic                  r_flagCarry;

   logic [DATA_W:0]       w_sum;
   logic [DATA_W:0]       w_diff;
   logic [DATA_W:0]       w_shl;
   logic [DATA_W:0]       w_shr;
   logic [DATA_W-1:0]     w_aluResult;
   logic                  w_aluCarry;
   logic [DATA_W-1:0]     w_mulAddend;
   logic [DATA_W:0]       w_mulUpper;
   logic [2*DATA_W-1:0]   w_mulNext;

   // Single-cycle ALU; the extra top/bottom bit of each wide intermediate
   // catches the carry, the borrow or the last bit shifted out.
   always_comb begin
      w_sum       = {1'b0, r_opA} + {1'b0, r_opB};
      w_diff      = {1'b0, r_opA} - {1'b0, r_opB};
      w_shl       = {1'b0, r_opA} << r_opB[SHIFT_W-1:0];
      w_shr       = {r_opA, 1'b0} >> r_opB[SHIFT_W-1:0];
      w_aluResult = '0;
      w_aluCarry  = 1'b0;
      case (r_opcode)
         OP_ADD: begin
            w_aluResult = w_sum[DATA_W-1:0];
            w_aluCarry  = w_sum[DATA_W];
         end
         OP_SUB: begin
            w_aluResult = w_diff[DATA_W-1:0];
            w_aluCarry  = w_diff[DATA_W];
         end
         OP_AND: w_aluResult = r_opA & r_opB;
         OP_OR:  w_aluResult = r_opA | r_opB;
         OP_XOR: w_aluResult = r_opA ^ r_opB;
         OP_SHL: begin
            w_aluResult = w_shl[DATA_W-1:0];
            w_aluCarry  = w_shl[DATA_W];
         end
         OP_SHR: begin
            w_aluResult = w_shr[DATA_W:1];
            w_aluCarry  = w_shr[0];
         end
         default: begin
            w_aluResult = '0;
            w_aluCarry  = 1'b0;
         end
      endcase
   end

   // One shift-add multiply step: the multiplier sits in the low half of the
   // product register and is consumed LSB first as partial sums shift in.
   always_comb begin
      w_mulAddend = r_mulProd[0] ? r_opA : '0;
      w_mulUpper  = {1'b0, r_mulProd[2*DATA_W-1:DATA_W]} + {1'b0, w_mulAddend};
      w_mulNext   = {w_mulUpper, r_mulProd[DATA_W-1:1]};
   end

   // Sequencer FSM with every output registered; writeEnable and done are
   // pulsed by loading them on the edge into WB and clearing them by default.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state          <= ST_IDLE;
         r_opcode         <= OP_ADD;
         r_rd             <= '0;
         r_regSource1     <= '0;
         r_regSource2     <= '0;
         r_regDestination <= '0;
         r_opA            <= '0;
         r_opB            <= '0;
         r_result         <= '0;
         r_mulProd        <= '0;
         r_mulCount       <= '0;
         r_instReady      <= 1'b1;
         r_busy           <= 1'b0;
         r_writeEnable    <= 1'b0;
         r_done           <= 1'b0;
         r_flagZero       <= 1'b0;
         r_flagCarry      <= 1'b0;
      end else begin
         r_writeEnable <= 1'b0;
         r_done        <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.inst_valid) begin
                  r_opcode     <= opcode_t'(bus.opcode);
                  r_rd         <= bus.rd;
                  r_regSource1 <= bus.rs1;
                  r_regSource2 <= bus.rs2;
                  r_instReady  <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= ST_READ;
               end
            end
            ST_READ: begin
               r_opA      <= bus.data1;
               r_opB      <= bus.data2;
               r_mulProd  <= {{DATA_W{1'b0}}, bus.data2};
               r_mulCount <= '0;
               r_state    <= (r_opcode == OP_MUL) ? ST_MUL : ST_EXEC;
            end
            ST_EXEC: begin
               r_result         <= w_aluResult;
               r_flagZero       <= (w_aluResult == '0);
               r_flagCarry      <= w_aluCarry;
               r_regDestination <= r_rd;
               r_writeEnable    <= 1'b1;
               r_done           <= 1'b1;
               r_state          <= ST_WB;
            end
            ST_MUL: begin
               r_mulProd  <= w_mulNext;
               r_mulCount <= r_mulCount + 1'b1;
               if (r_mulCount == MUL_LAST) begin
                  r_result         <= w_mulNext[DATA_W-1:0];
                  r_flagZero       <= (w_mulNext[DATA_W-1:0] == '0);
                  r_flagCarry      <= |w_mulNext[2*DATA_W-1:DATA_W];
                  r_regDestination <= r_rd;
                  r_writeEnable    <= 1'b1;
                  r_done           <= 1'b1;
                  r_state          <= ST_WB;
               end
            end
            ST_WB: begin
               r_instReady <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_instReady <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.inst_ready     = r_instReady;
   assign bus.busy           = r_busy;
   assign bus.regSource1     = r_regSource1;
   assign bus.regSource2     = r_regSource2;
   assign bus.regDestination = r_regDestination;
   assign bus.writeData      = r_result;
   assign bus.writeEnable    = r_writeEnable;
   assign bus.done           = r_done;
   assign bus.flag_zero      = r_flagZero;
   assign bus.flag_carry     = r_flagCarry;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: an 8x16 register file with R0 hardwired to zero,
// a table of directed vectors, hand-written reset / abort / held-valid
// sequences, and randomized instruction streams against a reference model.
module tb_exec_sequencer;

   localparam int DW = 16;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] expRes;
      logic        expZ;
      logic        expC;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        loadEn;
   logic [2:0]  loadAddr;
   logic [15:0] loadData;
   logic [15:0] rf [8];
   logic [15:0] mrf [8];
   int          wePulses;
   int          doneCount;
   int          acceptCount;
   int          totalChecks;
   int          passedChecks;
   vec_t        vecs [13];

   exec_sequencer_if #(.DATA_W(DW)) bus ();

   exec_sequencer #(.DATA_W(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Combinational register-file reads with R0 hardwired to zero.
   assign bus.data1 = (bus.regSource1 == 3'd0) ? 16'h0000 : rf[bus.regSource1];
   assign bus.data2 = (bus.regSource2 == 3'd0) ? 16'h0000 : rf[bus.regSource2];

   // Register-file writes (bench preload or DUT write-back) and event counters.
   always @(posedge clock) begin
      if (loadEn) begin
         if (loadAddr != 3'd0) rf[loadAddr] <= loadData;
      end else if (bus.writeEnable && bus.regDestination != 3'd0) begin
         rf[bus.regDestination] <= bus.writeData;
      end
      if (bus.writeEnable) wePulses <= wePulses + 1;
      if (bus.done) doneCount <= doneCount + 1;
      if (reset && bus.inst_valid && bus.inst_ready) acceptCount <= acceptCount + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalChecks++;
      if (act === exp) passedChecks++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic loadReg(input logic [2:0] addr, input logic [15:0] data);
      loadEn   = 1'b1;
      loadAddr = addr;
      loadData = data;
      tick();
      loadEn   = 1'b0;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      while (bus.busy && n < 60) begin
         tick();
         n++;
      end
      checkOutput({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
   endtask

   // Reference model: results straight from the arithmetic definition of
   // each opcode on plain integers.
   function automatic void refModel(input logic [2:0] op, input logic [15:0] a,
                                    input logic [15:0] b, output logic [15:0] res,
                                    output logic c);
      int          ai;
      int          bi;
      int          n;
      longint      p;
      ai = int'(a);
      bi = int'(b);
      n  = bi % 16;
      c  = 1'b0;
      case (op)
         3'd0: begin res = 16'((ai + bi) % 65536); c = (ai + bi) > 65535; end
         3'd1: begin res = 16'((ai - bi + 65536) % 65536); c = ai < bi; end
         3'd2: res = a & b;
         3'd3: res = a | b;
         3'd4: res = a ^ b;
         3'd5: begin
            res = 16'((ai * (1 << n)) % 65536);
            c   = (n == 0) ? 1'b0 : 1'(((ai >> (16 - n)) % 2));
         end
         3'd6: begin
            res = 16'(ai >> n);
            c   = (n == 0) ? 1'b0 : 1'(((ai >> (n - 1)) % 2));
         end
         default: begin
            p   = longint'(ai) * longint'(bi);
            res = 16'(p % 65536);
            c   = (p / 65536) != 0;
         end
      endcase
   endfunction

   // Issue one instruction from IDLE, follow it to write-back and check the
   // latency, the write-back port, the flags and the register file.
   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rd,
                                input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic [15:0] expRes, input logic expZ,
                                input logic expC, input string tag);
      int cyc;
      checkOutput({tag, "_ready"}, {31'd0, bus.inst_ready}, 32'd1);
      bus.opcode     = op;
      bus.rd         = rd;
      bus.rs1        = rs1;
      bus.rs2        = rs2;
      bus.inst_valid = 1'b1;
      tick();
      bus.inst_valid = 1'b0;
      checkOutput({tag, "_src1"}, {29'd0, bus.regSource1}, {29'd0, rs1});
      cyc = 1;
      while (!bus.writeEnable && cyc < 40) begin
         tick();
         cyc++;
      end
      checkOutput({tag, "_latency"}, cyc, (op == 3'd7) ? 32'd18 : 32'd3);
      checkOutput({tag, "_wdata"}, {16'd0, bus.writeData}, {16'd0, expRes});
      checkOutput({tag, "_dest"}, {29'd0, bus.regDestination}, {29'd0, rd});
      checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd1);
      tick();
      checkOutput({tag, "_we_off"}, {31'd0, bus.writeEnable}, 32'd0);
      checkOutput({tag, "_busy_off"}, {31'd0, bus.busy}, 32'd0);
      checkOutput({tag, "_zero"}, {31'd0, bus.flag_zero}, {31'd0, expZ});
      checkOutput({tag, "_carry"}, {31'd0, bus.flag_carry}, {31'd0, expC});
      if (rd != 3'd0) checkOutput({tag, "_rf"}, {16'd0, rf[rd]}, {16'd0, expRes});
   endtask

   initial begin
      int          weBefore;
      int          acc0;
      int          dn0;
      int          cyc;
      int          readyViol;
      logic [15:0] res;
      logic        c;
      logic [2:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;

      totalChecks  = 0;
      passedChecks = 0;
      wePulses     = 0;
      doneCount    = 0;
      acceptCount  = 0;
      reset          = 1'b0;
      loadEn         = 1'b0;
      loadAddr       = 3'd0;
      loadData       = 16'h0000;
      bus.inst_valid = 1'b0;
      bus.opcode     = 3'd2;
      bus.rd         = 3'd0;
      bus.rs1        = 3'd0;
      bus.rs2        = 3'd0;

      vecs[0]  = '{3'd0, 3'd3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};
      vecs[1]  = '{3'd1, 3'd4, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1};
      vecs[2]  = '{3'd7, 3'd5, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1};
      vecs[3]  = '{3'd0, 3'd6, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vecs[4]  = '{3'd2, 3'd7, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
      vecs[5]  = '{3'd3, 3'd3, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0};
      vecs[6]  = '{3'd4, 3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
      vecs[7]  = '{3'd5, 3'd5, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1};
      vecs[8]  = '{3'd6, 3'd6, 16'h0003, 16'h0001, 16'h0001, 1'b0, 1'b1};
      vecs[9]  = '{3'd5, 3'd7, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
      vecs[10] = '{3'd6, 3'd3, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
      vecs[11] = '{3'd7, 3'd4, 16'h00FF, 16'h0003, 16'h02FD, 1'b0, 1'b0};
      vecs[12] = '{3'd1, 3'd6, 16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b0};

      // Reset phase: clear the register file, then hold valid during reset.
      for (int i = 1; i < 8; i++) loadReg(3'(i), 16'h0000);
      bus.inst_valid = 1'b1;
      tick();
      tick();
      checkOutput("rst_ready", {31'd0, bus.inst_ready}, 32'd1);
      checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("rst_we", {31'd0, bus.writeEnable}, 32'd0);
      checkOutput("rst_zero", {31'd0, bus.flag_zero}, 32'd0);
      checkOutput("rst_carry", {31'd0, bus.flag_carry}, 32'd0);
      checkOutput("rst_src1", {29'd0, bus.regSource1}, 32'd0);
      checkOutput("rst_wdata", {16'd0, bus.writeData}, 32'd0);
      checkOutput("rst_noaccept", acceptCount, 32'd0);

      // Release reset with valid still high: accept on the first live edge.
      reset = 1'b1;
      tick();
      checkOutput("first_accept", {31'd0, bus.busy}, 32'd1);
      bus.inst_valid = 1'b0;
      waitIdle("first");

      // Directed vectors: operands in R1/R2.
      for (int i = 0; i < 13; i++) begin
         loadReg(3'd1, vecs[i].a);
         loadReg(3'd2, vecs[i].b);
         applyStimulus(vecs[i].op, vecs[i].rd, 3'd1, 3'd2, vecs[i].expRes,
                       vecs[i].expZ, vecs[i].expC, $sformatf("vec%0d", i));
      end

      // MUL abandoned by reset in its fifth MUL cycle.
      loadReg(3'd1, 16'h0100);
      loadReg(3'd2, 16'h0100);
      loadReg(3'd5, 16'h5A5A);
      weBefore       = wePulses;
      bus.opcode     = 3'd7;
      bus.rd         = 3'd5;
      bus.rs1        = 3'd1;
      bus.rs2        = 3'd2;
      bus.inst_valid = 1'b1;
      tick();
      bus.inst_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checkOutput("abort_ready", {31'd0, bus.inst_ready}, 32'd1);
      checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
      repeat (25) tick();
      checkOutput("abort_no_we", wePulses - weBefore, 32'd0);
      checkOutput("abort_rf5", {16'd0, rf[5]}, 32'h5A5A);

      // Valid held high through XOR rd=0, rs1=rs2=1.
      loadReg(3'd1, 16'h3C3C);
      acc0           = acceptCount;
      dn0            = doneCount;
      readyViol      = 0;
      bus.opcode     = 3'd4;
      bus.rd         = 3'd0;
      bus.rs1        = 3'd1;
      bus.rs2        = 3'd1;
      bus.inst_valid = 1'b1;
      tick();
      cyc = 1;
      while (!bus.writeEnable && cyc < 40) begin
         if (bus.inst_ready) readyViol++;
         tick();
         cyc++;
      end
      if (bus.inst_ready) readyViol++;
      checkOutput("hold_latency", cyc, 32'd3);
      checkOutput("hold_ready_low", readyViol, 32'd0);
      checkOutput("hold_dest", {29'd0, bus.regDestination}, 32'd0);
      checkOutput("hold_wdata", {16'd0, bus.writeData}, 32'd0);
      tick();
      checkOutput("hold_ready_back", {31'd0, bus.inst_ready}, 32'd1);
      checkOutput("hold_zero", {31'd0, bus.flag_zero}, 32'd1);
      checkOutput("hold_one_accept", acceptCount - acc0, 32'd1);
      checkOutput("hold_one_done", doneCount - dn0, 32'd1);
      tick();
      checkOutput("hold_next_accept", acceptCount - acc0, 32'd2);
      checkOutput("hold_next_busy", {31'd0, bus.busy}, 32'd1);
      bus.inst_valid = 1'b0;
      waitIdle("hold");

      // Randomized instruction stream against the reference model.
      mrf[0] = 16'h0000;
      for (int i = 1; i < 8; i++) begin
         case (i)
            1:       mrf[i] = 16'hFFFF;
            2:       mrf[i] = 16'h0000;
            default: mrf[i] = 16'($urandom);
         endcase
         loadReg(3'(i), mrf[i]);
      end
      for (int t = 0; t < 48; t++) begin
         op  = 3'($urandom_range(0, 7));
         rd  = 3'($urandom_range(0, 7));
         rs1 = 3'($urandom_range(0, 7));
         rs2 = 3'($urandom_range(0, 7));
         refModel(op, mrf[rs1], mrf[rs2], res, c);
         applyStimulus(op, rd, rs1, rs2, res, (res == 16'h0000), c,
                       $sformatf("rnd%0d_op%0d", t, op));
         if (rd != 3'd0) mrf[rd] = res;
      end
      for (int i = 1; i < 8; i++)
         checkOutput($sformatf("final_r%0d", i), {16'd0, rf[i]}, {16'd0, mrf[i]});

      $display("%0d/%0d checks passed", passedChecks, totalChecks);
      $finish;
   end

endmodule
